xge_sync_src: RTL

//  Launching end of a req/ack word crossing: runs entirely in the fast source clock domain.

---
 rtl/xge_sync_pkg.sv | 16 +
 rtl/xge_sync_bit.sv | 34 +++
 rtl/xge_sync_src.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/xge_sync_pkg.sv
// Shared definitions for the xge req/ack word-crossing source side.
package xge_sync_pkg;

    // One-hot handshake states.
    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_REQ    = 4'b0010,
        S_ACK_LO = 4'b0100,
        S_HOLD   = 4'b1000
    } state_t;

    // Width and saturation value of the coalesced-update counter.
    localparam int COAL_W = 16;
    localparam logic [COAL_W-1:0] COAL_MAX = '1;

endpackage

// File: rtl/xge_sync_bit.sv
// Two-flop single-bit synchronizer. The flops are kept as discrete registers
// (no shift-register packing) so they can be placed close together.
module xge_sync_bit (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *) logic s0_q;
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *) logic s1_q;
    logic s0_d;
    logic s1_d;

    // Next values: shift the asynchronous input through both stages.
    always_comb begin
        s0_d = d;
        s1_d = s0_q;
    end

    // Synchronizer stages with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q <= 1'b0;
            s1_q <= 1'b0;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
        end
    end

    assign q = s1_q;

endmodule

// File: rtl/xge_sync_src.sv
// Source side of a 4-phase req/ack word crossing. Holds a status word stable
// on data_out while req is high, coalesces updates that arrive mid-handshake
// and periodically re-sends the latest word even without new input.
module xge_sync_src
    import xge_sync_pkg::*;
#(
    parameter int             W          = 32,
    parameter logic [W-1:0]   OUT_PRESET = '0,
    parameter int             PERIOD     = 64,
    parameter int             HOLDOFF    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      in,
    input  logic              in_vld,
    input  logic              ack_async,
    output logic              req,
    output logic [W-1:0]      data_out,
    output logic              busy,
    output logic [COAL_W-1:0] coalesced
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLDOFF - 1);

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                busy_q, busy_d;
    logic [W-1:0]        data_q, data_d;
    logic [W-1:0]        pend_word_q, pend_word_d;
    logic                pend_q, pend_d;
    logic [PW-1:0]       period_cnt_q, period_cnt_d;
    logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [COAL_W-1:0]   coal_q, coal_d;
    logic [1:0]          settle_q, settle_d;

    logic                ack_s1;
    logic                refresh;
    logic                hold_done;
    logic                launch;

    xge_sync_bit u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_async),
        .q   (ack_s1)
    );

    // Launch decision. The synchronizer comes out of reset reading 0 even if the
    // receiver is still holding ack, so launches wait until it has refilled.
    always_comb begin
        refresh   = (period_cnt_q == PERIOD_LAST);
        hold_done = (hold_cnt_q == HOLD_LAST);
        launch    = (state_q == S_IDLE) && (pend_q || in_vld || refresh)
                    && !ack_s1 && settle_q[1];
    end

    // Next-state logic for the handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (launch)     state_d = S_REQ;
            S_REQ:    if (ack_s1)     state_d = S_ACK_LO;
            S_ACK_LO: if (!ack_s1)    state_d = S_HOLD;
            S_HOLD:   if (hold_done)  state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // Registered outputs derived from the next state.
    always_comb begin
        req_d  = (state_d == S_REQ);
        busy_d = (state_d != S_IDLE);
    end

    // Word capture, pending/coalesce bookkeeping and the period/hold counters.
    always_comb begin
        data_d       = data_q;
        pend_word_d  = pend_word_q;
        pend_d       = pend_q;
        coal_d       = coal_q;
        period_cnt_d = period_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        settle_d     = settle_q[1] ? settle_q : settle_q + 2'd1;

        if (in_vld) begin
            pend_word_d = in;
            pend_d      = 1'b1;
            if (pend_q && !launch && (coal_q != COAL_MAX)) begin
                coal_d = coal_q + COAL_W'(1);
            end
        end

        if (launch) begin
            data_d       = in_vld ? in : pend_word_q;
            pend_d       = 1'b0;
            period_cnt_d = '0;
        end else if ((state_q == S_IDLE) && !refresh) begin
            period_cnt_d = period_cnt_q + PW'(1);
        end

        if ((state_q == S_ACK_LO) && !ack_s1) begin
            hold_cnt_d = '0;
        end else if ((state_q == S_HOLD) && !hold_done) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
            data_q       <= OUT_PRESET;
            pend_word_q  <= OUT_PRESET;
            pend_q       <= 1'b0;
            period_cnt_q <= '0;
            hold_cnt_q   <= '0;
            coal_q       <= '0;
            settle_q     <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            busy_q       <= busy_d;
            data_q       <= data_d;
            pend_word_q  <= pend_word_d;
            pend_q       <= pend_d;
            period_cnt_q <= period_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            coal_q       <= coal_d;
            settle_q     <= settle_d;
        end
    end

    assign req       = req_q;
    assign busy      = busy_q;
    assign data_out  = data_q;
    assign coalesced = coal_q;

endmodule
